instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 15 +
 rtl/pc_next_gen.sv | 17 +
 rtl/instr_fetch.sv | 89 ++++++++
 tb/tb_instr_fetch.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch FSM state encoding
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    RST_S   = 3'd0,
    REQ_S   = 3'd1,
    WAIT_S  = 3'd2,
    VALID_S = 3'd3,
    FAULT_S = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/pc_next_gen.sv
// rtl/pc_next_gen.sv - combinational next-PC target and alignment check
module pc_next_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] immediate,
  input  logic            branch,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  always_comb begin
    target     = branch ? (pc + immediate) : (pc + 32'd4);
    misaligned = |target[1:0];
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit
// Optional FETCH_MISALIGN_TRAP_EN: trap on misaligned redirect instead of truncating.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic [31:0] immediate,
  output logic [31:0] fetch_count,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_t state;
  logic [XLEN-1:0] target;
  logic misaligned;
  logic fault_q;
  logic handshake;

  pc_next_gen u_pc_next_gen (
    .pc         (pc_out),
    .immediate  (immediate),
    .branch     (branch),
    .target     (target),
    .misaligned (misaligned)
  );

  assign handshake   = instr_valid & instr_ready;
  assign imem_req    = (state == REQ_S);
  assign imem_addr   = pc_out;
  assign fetch_fault = TRAP_EN ? fault_q : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RST_S;
      pc_out      <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      fetch_count <= '0;
      fault_q     <= 1'b0;
    end else begin
      case (state)
        RST_S:   state <= REQ_S;
        REQ_S:   if (imem_gnt) state <= WAIT_S;
        WAIT_S: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= VALID_S;
          end
        end
        VALID_S: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            fetch_count <= fetch_count + 32'd1;
            // A trapped redirect keeps pc_out pointing at the faulting instruction.
            if (TRAP_EN && misaligned) begin
              fault_q <= 1'b1;
              state   <= FAULT_S;
            end else begin
              pc_out <= TRAP_EN ? target : {target[31:2], 2'b00};
              state  <= REQ_S;
            end
          end
        end
        FAULT_S: state <= FAULT_S;
        default: state <= RST_S;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic [31:0] immediate;
  logic [31:0] fetch_count;
  logic        fetch_fault;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_count = 32'd0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .immediate   (immediate),
    .fetch_count (fetch_count),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc_out, 32'h0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
    check({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  // Called at a negedge with the DUT expected in REQ_S at address pc.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] d, input logic br,
                       input logic [31:0] imm, input int stall);
    check("req", {31'd0, imem_req}, 32'd1);
    check("addr", imem_addr, pc);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    check("valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, d);
    check("pc", pc_out, pc);
    for (int i = 0; i < stall; i++) begin
      instr_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instr, d);
      check("stall_pc", pc_out, pc);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_count", fetch_count, exp_count);
    end
    instr_ready = 1'b1;
    branch      = br;
    immediate   = imm;
    @(negedge clk);
    instr_ready = 1'b0;
    branch      = 1'b0;
    immediate   = 32'h0;
    exp_count   = exp_count + 32'd1;
    check("valid_clr", {31'd0, instr_valid}, 32'd0);
    check("count", fetch_count, exp_count);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 32'd0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    branch = 1'b0;
    immediate = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);

    // Sequential fetches, then a forward branch to 0x100.
    fetch(32'h0000_0000, 32'h0010_0093, 1'b0, 32'h0, 0);
    fetch(32'h0000_0004, 32'h0020_0113, 1'b0, 32'h0, 0);
    fetch(32'h0000_0008, 32'h0030_0193, 1'b1, 32'h0000_00F8, 0);
    check("count3", fetch_count, 32'd3);
    // Stall five cycles, then backward branch -8.
    fetch(32'h0000_0100, 32'h0040_0213, 1'b1, 32'hFFFF_FFF8, 5);
    check("count_stall", fetch_count, 32'd4);
    fetch(32'h0000_00F8, 32'h0050_0293, 1'b1, 32'hFFFF_FF04, 0);
    // Sequential step wraps from 0xFFFF_FFFC to 0.
    fetch(32'hFFFF_FFFC, 32'h0060_0313, 1'b0, 32'h0, 0);
    fetch(32'h0000_0000, 32'h0070_0393, 1'b1, 32'h0000_0010, 0);
    fetch(32'h0000_0010, 32'h0080_0413, 1'b1, 32'h0000_0006, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      check("fault", {31'd0, fetch_fault}, 32'd1);
      check("fault_pc", pc_out, 32'h0000_0010);
      check("fault_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end
`else
    check("nofault", {31'd0, fetch_fault}, 32'd0);
    check("trunc_addr", imem_addr, 32'h0000_0014);
`endif
    pulse_reset();

    // Reset while a response is pending; the late rvalid must be dropped.
    check("pre_req", {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_reset_state("wrst");
    rst = 1'b0;
    exp_count = 32'd0;
    @(negedge clk);
    check("late_valid", {31'd0, instr_valid}, 32'd0);
    check("late_instr", instr, 32'h0000_0013);
    imem_rvalid = 1'b0;
    fetch(32'h0000_0000, 32'h0090_0493, 1'b0, 32'h0, 0);
    check("recover_addr", imem_addr, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
